seq_lut_loader: RTL and testbench
=================================

// Module: seq_lut_loader
// PURPOSE
//  Upstream loader for sequencer_fsm's 29-bit command LUT. Takes host bytes on a valid/ready stream,
//  packs 4 bytes per entry and writes entries via lut_wen. Then rewinds the sequencer address and
//  reads the LUT back through lut_rden, checking a 32-bit checksum. Holds the sequencer in reset
//  until a verified load completes.
// PARAMETERS
//  ENTRY_W     29  LUT entry width (== sequencer lut_write_data width)
//  ADDR_W      8   LUT address width; max entries = 2**ADDR_W
//  REWIND_CYC  2   cycles seq_reset_o is re-pulsed between write and verify phases (>=1)
// PORTS
//  clk               in   1          single clock, all logic posedge
//  reset_n_i         in   1          asynchronous, active-low reset
//  start_i           in   1          1-cycle pulse: begin load; sampled only in IDLE
//  abort_i           in   1          abandon load, return to IDLE (seq_reset_o stays 1)
//  entry_count_i     in   ADDR_W+1   entries to load, 0..2**ADDR_W; latched on start_i
//  s_data_i          in   8          host byte, little-endian within entry
//  s_valid_i         in   1          byte valid
//  s_ready_o         out  1          byte accepted when s_valid_i & s_ready_o
//  seq_reset_o       out  1          drives sequencer reset_i (active high)
//  lut_wen_o         out  1          1-cycle write strobe; sequencer auto-increments address
//  lut_write_data_o  out  ENTRY_W    entry to write, valid with lut_wen_o
//  lut_rden_o        out  1          1-cycle read strobe; sequencer auto-increments address
//  lut_read_data_i   in   ENTRY_W    combinational LUT data at current sequencer address
//  busy_o            out  1          state != IDLE
//  done_o            out  1          1-cycle pulse at end of every load (pass or fail)
//  error_o           out  1          sticky checksum mismatch; cleared on next accepted start_i
//  entries_done_o    out  ADDR_W+1   entries written in current/last load
// BEHAVIOUR
//  Reset: state IDLE; seq_reset_o=1; s_ready_o, lut_wen_o, lut_rden_o, done_o, error_o = 0;
//   lut_write_data_o, entries_done_o, checksums = 0.
//  seq_reset_o=1 from reset until the first passing load. A failed or aborted load keeps it at 1.
//  FSM states: IDLE, COLLECT, WRITE, REWIND, VERIFY, CHECK, RELEASE.
//  IDLE: s_ready_o=0. On start_i:
//   - count==0 -> done_o next cycle, no strobes, seq_reset_o unchanged.
//   - else -> seq_reset_o=1, clear error_o/checksums/counters, go COLLECT.
//  COLLECT: s_ready_o=1. Byte k (0..3) goes to bits [8k+7:8k]. Bits above ENTRY_W-1 are discarded.
//   On 4th accepted byte go WRITE.
//  WRITE (1 cycle, s_ready_o=0): lut_wen_o=1 with packed entry; wr_sum += entry (mod 2^32, zero-ext);
//   entries_done_o++. Go COLLECT if more entries remain, else REWIND.
//   Throughput: 5 cycles/entry with continuous valid.
//  REWIND: hold seq_reset_o=1 for REWIND_CYC cycles (sequencer address -> 0), then go VERIFY.
//  VERIFY: lut_rden_o=1 every cycle for exactly count cycles. Sample lut_read_data_i in the strobe
//   cycle, before the address increments; rd_sum += data. Then go CHECK.
//  CHECK (1 cycle): error_o <= (rd_sum != wr_sum); done_o=1. On pass go RELEASE, on fail go IDLE.
//  RELEASE (1 cycle): seq_reset_o<=0; go IDLE. Sequencer starts from LUT address 0.
//  lut_wen_o and lut_rden_o are never high in the same cycle; both are 0 outside WRITE and VERIFY.
//  count==2**ADDR_W: sequencer address wraps to 0 after the last write; rewind is still applied.
//  abort_i (any non-IDLE state; priority over all transitions): next cycle IDLE, strobes 0,
//   partial byte discarded, seq_reset_o=1, done_o=0, error_o unchanged.
//  start_i outside IDLE is ignored. s_valid_i outside COLLECT is not accepted.
//  Reset mid-load: immediate return to reset values; the LUT is treated as invalid.
// STRUCTURE
//  seq_pkg: ENTRY_W/ADDR_W constants, LUT field offsets (state[2:0], repeat[10:3], len[26:11],
//   eof[27], sof[28]), loader_state_t enum. Shared with sequencer_fsm.
//  Sub-module lut_entry_packer: byte counter + 32-bit shift reg, entry_valid pulse on 4th byte,
//   flush input for abort.
//  Top: FSM, entry/verify counters, two 32-bit accumulators, rewind timer.
// TESTING (bench includes behavioural sequencer LUT model with auto-increment and reset rewind)
//  1 count=6, 24 bytes, continuous valid -> 6 wen pulses 5 cycles apart, entry0=0x0000_3202
//    from bytes 02,32,00,00; 2-cycle rewind; 6 rden; done_o, error_o=0; seq_reset_o falls 1 cycle
//    after done_o.
//  2 same load with random s_valid gaps -> identical LUT contents and result; s_ready_o=0 in WRITE.
//  3 model corrupts entry 3 bit 27 on readback -> error_o=1, done_o pulse, seq_reset_o stays 1;
//    next start_i clears error_o.
//  4 count=0 -> done_o 1 cycle after start_i, no wen/rden, busy_o high for 1 cycle only.
//  5 abort_i after 2 bytes of entry 1; separately, reset_n_i low mid-VERIFY -> IDLE,
//    seq_reset_o=1, no done_o; fresh load then passes.
//  6 count=256 with byte 0xFF in bits [31:29] -> bits ignored, 256 writes, address wraps, pass.

Source files
------------

// File: rtl/seq_lut_loader_pkg.sv
// -----------------------------------------------------------------------------
// seq_lut_loader_pkg
// Shared definitions for the sequencer command LUT and its upstream loader:
// LUT geometry, entry field layout, checksum width and the loader FSM states.
// Also imported by sequencer_fsm, so field positions here define the LUT format.
// -----------------------------------------------------------------------------
package seq_lut_loader_pkg;

  // LUT geometry (matches sequencer lut_write_data / address widths)
  localparam int LUT_ENTRY_W    = 29;
  localparam int LUT_ADDR_W     = 8;
  localparam int LUT_REWIND_CYC = 2;

  // Both checksums are plain 32-bit modular sums of zero-extended entries
  localparam int SUM_W = 32;

  // Entry field layout, MSB first:
  //   sof[28] eof[27] len[26:11] repeat[10:3] state[2:0]
  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [15:0] len;
    logic [7:0]  rpt;
    logic [2:0]  state;
  } lut_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_REWIND  = 3'd3,
    ST_VERIFY  = 3'd4,
    ST_CHECK   = 3'd5,
    ST_RELEASE = 3'd6
  } loader_state_t;

endpackage

// File: rtl/seq_lut_loader_packer.sv
// -----------------------------------------------------------------------------
// seq_lut_loader_packer
// Packs four little-endian host bytes into one LUT entry. The first three bytes
// are held in a 24-bit register; the fourth is taken straight from the input so
// the complete entry is available in the same cycle the last byte is accepted.
// Bits above ENTRY_W-1 are dropped. flush_i discards any partial entry.
//
// Ports
//   clk            clock
//   reset_n_i      asynchronous active-low reset
//   flush_i        drop partial entry, restart at byte 0 (wins over byte_valid_i)
//   byte_valid_i   byte_i accepted this cycle
//   byte_i         host byte
//   entry_valid_o  fourth byte accepted this cycle; entry_o is complete
//   entry_o        packed entry (valid with entry_valid_o)
// -----------------------------------------------------------------------------
module seq_lut_loader_packer
  import seq_lut_loader_pkg::*;
#(
  parameter int ENTRY_W = LUT_ENTRY_W
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic               entry_valid_o,
  output logic [ENTRY_W-1:0] entry_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] word_q, word_d;

  // NOTE: every signal written here gets its default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;  // wraps 3 -> 0 after the entry completes
      case (cnt_q)
        2'd0:    word_d[7:0]   = byte_i;
        2'd1:    word_d[15:8]  = byte_i;
        2'd2:    word_d[23:16] = byte_i;
        default: ;  // fourth byte bypasses the register
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign entry_valid_o = byte_valid_i && !flush_i && (cnt_q == 2'd3);
  // Truncating cast drops bits [31:ENTRY_W] of the host word
  assign entry_o       = ENTRY_W'({byte_i, word_q});

endmodule

// File: rtl/seq_lut_loader.sv
// -----------------------------------------------------------------------------
// seq_lut_loader
// Loads the sequencer command LUT from a host byte stream, then rewinds the
// sequencer address and reads every entry back, comparing a 32-bit sum of what
// was written with a sum of what is read. The sequencer is held in reset until
// a load verifies; failed or aborted loads leave it in reset.
//
// Ports
//   clk               clock, all logic on posedge
//   reset_n_i         asynchronous active-low reset
//   start_i           begin a load (IDLE only)
//   abort_i           abandon the load, back to IDLE, sequencer stays in reset
//   entry_count_i     entries to load, 0..2**ADDR_W, latched on start_i
//   s_data_i          host byte, little-endian within an entry
//   s_valid_i         host byte valid
//   s_ready_o         byte accepted when s_valid_i & s_ready_o
//   seq_reset_o       sequencer reset (active high)
//   lut_wen_o         write strobe; sequencer post-increments its address
//   lut_write_data_o  entry to write, valid with lut_wen_o
//   lut_rden_o        read strobe; sequencer post-increments its address
//   lut_read_data_i   LUT data at the current sequencer address
//   busy_o            FSM not in IDLE
//   done_o            one-cycle pulse at the end of each load
//   error_o           sticky checksum mismatch, cleared by the next load start
//   entries_done_o    entries written in the current/last load
// -----------------------------------------------------------------------------
module seq_lut_loader
  import seq_lut_loader_pkg::*;
#(
  parameter int ENTRY_W    = LUT_ENTRY_W,   // must not exceed 32
  parameter int ADDR_W     = LUT_ADDR_W,
  parameter int REWIND_CYC = LUT_REWIND_CYC // >= 1
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [ADDR_W:0]    entry_count_i,
  input  logic [7:0]         s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic               seq_reset_o,
  output logic               lut_wen_o,
  output logic [ENTRY_W-1:0] lut_write_data_o,
  output logic               lut_rden_o,
  input  logic [ENTRY_W-1:0] lut_read_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [ADDR_W:0]    entries_done_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RW_W  = (REWIND_CYC > 1) ? $clog2(REWIND_CYC) : 1;
  localparam logic [RW_W-1:0] RW_LAST = RW_W'(REWIND_CYC - 1);

  loader_state_t      state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   entries_q, entries_d;
  logic [CNT_W-1:0]   verify_q, verify_d;
  logic [RW_W-1:0]    rewind_q, rewind_d;
  logic [SUM_W-1:0]   wr_sum_q, wr_sum_d;
  logic [SUM_W-1:0]   rd_sum_q, rd_sum_d;
  logic [ENTRY_W-1:0] wdata_q, wdata_d;
  logic               seq_reset_q, seq_reset_d;
  logic               error_q, error_d;
  logic               done_q, done_d;

  logic               flush;
  logic               byte_accept;
  logic               entry_valid;
  logic [ENTRY_W-1:0] entry;

  assign byte_accept = s_valid_i && s_ready_o;

  seq_lut_loader_packer #(
    .ENTRY_W (ENTRY_W)
  ) u_packer (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .flush_i       (flush),
    .byte_valid_i  (byte_accept),
    .byte_i        (s_data_i),
    .entry_valid_o (entry_valid),
    .entry_o       (entry)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    entries_d   = entries_q;
    verify_d    = verify_q;
    rewind_d    = rewind_q;
    wr_sum_d    = wr_sum_q;
    rd_sum_d    = rd_sum_q;
    wdata_d     = wdata_q;
    seq_reset_d = seq_reset_q;
    error_d     = error_q;
    done_d      = 1'b0;
    flush       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          count_d   = entry_count_i;
          entries_d = '0;
          if (entry_count_i == '0) begin
            // Empty load: one pass through CHECK so done_o and busy_o each
            // show for exactly one cycle; seq_reset_o and error_o untouched.
            done_d  = 1'b1;
            state_d = ST_CHECK;
          end else begin
            seq_reset_d = 1'b1;
            error_d     = 1'b0;
            wr_sum_d    = '0;
            rd_sum_d    = '0;
            verify_d    = '0;
            flush       = 1'b1;
            state_d     = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (entry_valid) begin
          wdata_d = entry;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        wr_sum_d  = wr_sum_q + SUM_W'(wdata_q);
        entries_d = entries_q + CNT_W'(1);
        if (entries_d == count_q) begin
          rewind_d = '0;
          state_d  = ST_REWIND;
        end else begin
          state_d  = ST_COLLECT;
        end
      end

      ST_REWIND: begin
        // Sequencer address returns to 0 while seq_reset_o stays high
        seq_reset_d = 1'b1;
        if (rewind_q == RW_LAST) begin
          verify_d = '0;
          state_d  = ST_VERIFY;
        end else begin
          rewind_d = rewind_q + RW_W'(1);
        end
      end

      ST_VERIFY: begin
        // Read data belongs to the address before this strobe's increment
        rd_sum_d = rd_sum_q + SUM_W'(lut_read_data_i);
        verify_d = verify_q + CNT_W'(1);
        if (verify_d == count_q) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          error_d = (rd_sum_q != wr_sum_q);
          done_d  = 1'b1;
          state_d = (rd_sum_q == wr_sum_q) ? ST_RELEASE : ST_IDLE;
        end
      end

      ST_RELEASE: begin
        seq_reset_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every transition; error_o keeps its value
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      seq_reset_d = 1'b1;
      error_d     = error_q;
      done_d      = 1'b0;
      flush       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      entries_q   <= '0;
      verify_q    <= '0;
      rewind_q    <= '0;
      wr_sum_q    <= '0;
      rd_sum_q    <= '0;
      wdata_q     <= '0;
      seq_reset_q <= 1'b1;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      entries_q   <= entries_d;
      verify_q    <= verify_d;
      rewind_q    <= rewind_d;
      wr_sum_q    <= wr_sum_d;
      rd_sum_q    <= rd_sum_d;
      wdata_q     <= wdata_d;
      seq_reset_q <= seq_reset_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  // Strobes decode directly from state, so they can never overlap
  assign s_ready_o        = (state_q == ST_COLLECT);
  assign lut_wen_o        = (state_q == ST_WRITE);
  assign lut_rden_o       = (state_q == ST_VERIFY);
  assign busy_o           = (state_q != ST_IDLE);
  assign lut_write_data_o = wdata_q;
  assign seq_reset_o      = seq_reset_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign entries_done_o   = entries_q;

endmodule

// File: tb/tb_seq_lut_loader.sv
// -----------------------------------------------------------------------------
// tb_seq_lut_loader
// Scoreboard bench for seq_lut_loader with a behavioural sequencer LUT: writes
// and reads post-increment the address; while the sequencer is held in reset
// and the loader is not feeding bytes or strobing, the address rewinds to 0.
// -----------------------------------------------------------------------------
module tb_seq_lut_loader;
  import seq_lut_loader_pkg::*;

  localparam int EW = LUT_ENTRY_W;
  localparam int AW = LUT_ADDR_W;
  localparam logic [EW-1:0] CORRUPT_MASK = 29'h0800_0000;  // bit 27

  // Directed entries (host word, bytes sent LSB first) and hand-computed
  // 29-bit LUT values with bits [31:29] dropped.
  localparam logic [31:0] TAB_W [6] = '{32'h0000_3202, 32'h1234_5678, 32'hDEAD_BEEF,
                                        32'h0800_0001, 32'hFFFF_FFFF, 32'h4000_0A5C};
  localparam logic [EW-1:0] TAB_E [6] = '{29'h0000_3202, 29'h1234_5678, 29'h1EAD_BEEF,
                                          29'h0800_0001, 29'h1FFF_FFFF, 29'h0000_0A5C};

  logic            clk = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [AW:0]     entry_count_i = '0;
  logic [7:0]      s_data_i = '0;
  logic            s_valid_i = 1'b0;
  logic            s_ready_o, seq_reset_o, lut_wen_o, lut_rden_o;
  logic            busy_o, done_o, error_o;
  logic [EW-1:0]   lut_write_data_o, lut_read_data_i;
  logic [AW:0]     entries_done_o;

  always #5 clk = ~clk;

  seq_lut_loader dut (
    .clk              (clk),
    .reset_n_i        (reset_n_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .entry_count_i    (entry_count_i),
    .s_data_i         (s_data_i),
    .s_valid_i        (s_valid_i),
    .s_ready_o        (s_ready_o),
    .seq_reset_o      (seq_reset_o),
    .lut_wen_o        (lut_wen_o),
    .lut_write_data_o (lut_write_data_o),
    .lut_rden_o       (lut_rden_o),
    .lut_read_data_i  (lut_read_data_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .entries_done_o   (entries_done_o)
  );

  // ---------------- sequencer LUT model ----------------
  logic [EW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] addr = '0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = 8'd3;

  always @(posedge clk) begin
    if (lut_wen_o) begin
      mem[addr] <= lut_write_data_o;
      addr      <= addr + 1'b1;
    end else if (lut_rden_o) begin
      addr <= addr + 1'b1;
    end else if (seq_reset_o && !s_ready_o) begin
      addr <= '0;
    end
  end

  assign lut_read_data_i = mem[addr] ^ ((corrupt_en && addr == corrupt_addr) ? CORRUPT_MASK : '0);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic err;       // expected error_o with done_o
    logic sr_at;     // expected seq_reset_o in the done_o cycle
    logic sr_after;  // expected seq_reset_o one cycle later
  } done_exp_t;

  logic [EW-1:0] exp_wen_q [$];
  done_exp_t     exp_done_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   last_wen_cyc = -1;
  int   wen_total = 0;
  int   rden_total = 0;
  logic prev_rden = 1'b0;
  logic rel_pending = 1'b0;
  logic rel_exp = 1'b0;
  logic chk_space = 1'b0;

  initial begin
    logic [EW-1:0] e;
    done_exp_t d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rel_pending) begin
        check("seq_reset_after_done", seq_reset_o, rel_exp);
        rel_pending = 1'b0;
      end
      if (reset_n_i) begin
        if (lut_wen_o) begin
          wen_total++;
          check("ready_low_in_write", s_ready_o, 0);
          if (chk_space && last_wen_cyc >= 0) check("wen_spacing", cyc - last_wen_cyc, 5);
          last_wen_cyc = cyc;
          check("wen_expected", exp_wen_q.size() != 0, 1);
          if (exp_wen_q.size() != 0) begin
            e = exp_wen_q.pop_front();
            check("wen_data", lut_write_data_o, e);
          end
        end
        if (lut_rden_o) begin
          rden_total++;
          check("strobe_exclusive", lut_wen_o, 0);
          if (!prev_rden && last_wen_cyc >= 0)
            check("rewind_gap", cyc - last_wen_cyc, LUT_REWIND_CYC + 1);
        end
        prev_rden = lut_rden_o;
        if (done_o) begin
          check("done_expected", exp_done_q.size() != 0, 1);
          if (exp_done_q.size() != 0) begin
            d = exp_done_q.pop_front();
            check("done_error", error_o, d.err);
            check("seq_reset_at_done", seq_reset_o, d.sr_at);
            rel_pending = 1'b1;
            rel_exp     = d.sr_after;
          end
        end
        if (!busy_o) last_wen_cyc = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] word_for(input int i, input int src);
    if (src == 0) return TAB_W[i];
    return {8'hFF, 16'h0000, 8'(i)};
  endfunction

  function automatic logic [EW-1:0] exp_for(input int i, input int src);
    if (src == 0) return TAB_E[i];
    return 29'h1F00_0000 | 29'(i);
  endfunction

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic start_load(input int n);
    entry_count_i = (AW+1)'(n);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic seen;
    s_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_data_i  = b;
    s_valid_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = s_ready_o;
      @(posedge clk); #1;
    end
    check("byte_accepted", seen, 1);
    s_valid_i = 1'b0;
  endtask

  task automatic send_entry(input logic [31:0] w, input int max_gap);
    for (int b = 0; b < 4; b++)
      send_byte(w[8*b +: 8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = done_o;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input int n, input int src, input int max_gap,
                          input logic exp_err, input logic exp_sr_after);
    int wen0, rden0;
    done_exp_t d;
    for (int i = 0; i < n; i++) exp_wen_q.push_back(exp_for(i, src));
    d.err = exp_err; d.sr_at = 1'b1; d.sr_after = exp_sr_after;
    exp_done_q.push_back(d);
    wen0 = wen_total; rden0 = rden_total;
    start_load(n);
    check("busy_after_start", busy_o, 1);
    check("error_clear_on_start", error_o, 0);
    for (int i = 0; i < n; i++) send_entry(word_for(i, src), max_gap);
    wait_done(n + 40);
    check("wen_count", wen_total - wen0, n);
    check("rden_count", rden_total - rden0, n);
    check("entries_done", entries_done_o, n);
    check("scoreboard_drained", exp_wen_q.size() + exp_done_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wen0, rden0;
    logic seen;
    done_exp_t d;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seq_reset", seq_reset_o, 1);
    check("rst_s_ready", s_ready_o, 0);
    check("rst_wen", lut_wen_o, 0);
    check("rst_rden", lut_rden_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_wdata", lut_write_data_o, 0);
    check("rst_entries", entries_done_o, 0);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;

    // 1: six entries, continuous valid
    chk_space = 1'b1;
    run_load(6, 0, 0, 1'b0, 1'b0);
    chk_space = 1'b0;
    check("t1_lut0", mem[0], 29'h0000_3202);
    check("t1_lut5", mem[5], 29'h0000_0A5C);
    check("t1_seq_reset", seq_reset_o, 0);
    check("t1_busy", busy_o, 0);

    // 2: same load with random valid gaps
    run_load(6, 0, 3, 1'b0, 1'b0);
    check("t2_lut2", mem[2], 29'h1EAD_BEEF);
    check("t2_error", error_o, 0);

    // 3: corrupted readback of entry 3, then a clean load clears error_o
    corrupt_en = 1'b1;
    run_load(6, 0, 0, 1'b1, 1'b1);
    corrupt_en = 1'b0;
    check("t3_error_sticky", error_o, 1);
    check("t3_seq_reset_held", seq_reset_o, 1);
    run_load(6, 0, 0, 1'b0, 1'b0);

    // 4: empty load
    d.err = 1'b0; d.sr_at = 1'b0; d.sr_after = 1'b0;
    exp_done_q.push_back(d);
    wen0 = wen_total; rden0 = rden_total;
    start_load(0);
    check("t4_busy_cycle1", busy_o, 1);
    check("t4_done_cycle1", done_o, 1);
    @(posedge clk); #1;
    check("t4_busy_cycle2", busy_o, 0);
    check("t4_done_cycle2", done_o, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_no_wen", wen_total - wen0, 0);
    check("t4_no_rden", rden_total - rden0, 0);
    check("t4_seq_reset", seq_reset_o, 0);
    check("t4_drained", exp_done_q.size(), 0);

    // 5a: abort after two bytes of entry 1
    exp_wen_q.push_back(TAB_E[0]);
    start_load(6);
    send_entry(TAB_W[0], 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("t5a_busy", busy_o, 0);
    check("t5a_seq_reset", seq_reset_o, 1);
    check("t5a_s_ready", s_ready_o, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("t5a_error", error_o, 0);
    check("t5a_drained", exp_wen_q.size(), 0);

    // 5b: reset mid-VERIFY
    for (int i = 0; i < 6; i++) exp_wen_q.push_back(TAB_E[i]);
    start_load(6);
    for (int i = 0; i < 6; i++) send_entry(TAB_W[i], 0);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = lut_rden_o;
    end
    check("t5b_verify_reached", seen, 1);
    @(posedge clk); #1;
    reset_n_i = 1'b0;
    #1;
    check("t5b_busy", busy_o, 0);
    check("t5b_seq_reset", seq_reset_o, 1);
    check("t5b_done", done_o, 0);
    check("t5b_entries", entries_done_o, 0);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("t5b_drained", exp_wen_q.size() + exp_done_q.size(), 0);
    run_load(6, 0, 0, 1'b0, 1'b0);

    // 6: full 256-entry load, bits [31:29] set in every host word
    run_load(256, 1, 0, 1'b0, 1'b0);
    check("t6_lut0", mem[0], 29'h1F00_0000);
    check("t6_lut255", mem[255], 29'h1F00_00FF);
    check("t6_error", error_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
